// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the 5-stage MIPS core.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble and an optional
// skid slot that takes out_ready off the in_ready timing path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter int                 SKID   = 1,
  parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic accept;
  logic emit;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_e       state_q, state_d;
      logic [DATA_W-1:0] m_data_p0;
      logic [DATA_W-1:0] s_data_p0;
      logic              load_m_in;
      logic              load_m_s;
      logic              load_s;

      always_ff @(posedge clk) begin
        if (reset) state_q <= PIPE_EMPTY;
        else       state_q <= state_d;
      end

      always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        if (flush) begin
          state_d = PIPE_EMPTY;
        end else begin
          case (state_q)
            PIPE_EMPTY: begin
              if (accept) begin
                state_d   = PIPE_ONE;
                load_m_in = 1'b1;
              end
            end
            PIPE_ONE: begin
              if (accept && emit) begin
                load_m_in = 1'b1;
              end else if (accept) begin
                state_d = PIPE_TWO;
                load_s  = 1'b1;
              end else if (emit) begin
                state_d = PIPE_EMPTY;
              end
            end
            PIPE_TWO: begin
              if (emit) begin
                state_d  = PIPE_ONE;
                load_m_s = 1'b1;
              end
            end
            default: state_d = PIPE_EMPTY;
          endcase
        end
      end

      // Slot storage: main slot feeds the output, skid slot catches the one
      // beat accepted after downstream stalls.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          m_data_p0 <= BUBBLE;
          s_data_p0 <= BUBBLE;
        end else begin
          if (load_m_in)     m_data_p0 <= in_data;
          else if (load_m_s) m_data_p0 <= s_data_p0;
          if (load_s)        s_data_p0 <= in_data;
        end
      end

      always_comb begin
        occupancy = 2'd0;
        case (state_q)
          PIPE_ONE: occupancy = 2'd1;
          PIPE_TWO: occupancy = 2'd2;
          default:  occupancy = 2'd0;
        endcase
      end

      assign out_valid = (state_q == PIPE_ONE) || (state_q == PIPE_TWO);
      assign in_ready  = !reset && (state_q != PIPE_TWO);
      assign out_data  = m_data_p0;
    end else begin : g_single
      logic              vld_p0;
      logic [DATA_W-1:0] data_p0;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          vld_p0  <= 1'b0;
          data_p0 <= BUBBLE;
        end else if (accept) begin
          vld_p0  <= 1'b1;
          data_p0 <= in_data;
        end else if (emit) begin
          vld_p0  <= 1'b0;
        end
      end

      assign out_valid = vld_p0;
      assign in_ready  = !reset && (!vld_p0 || out_ready);
      assign out_data  = data_p0;
      assign occupancy = {1'b0, vld_p0};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random-backpressure bench for pipe_stage_reg, SKID=1 and SKID=0 side by side.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        fl;
  logic        s1_iv, s1_ir, s1_ov, s1_or;
  logic [31:0] s1_d, s1_od;
  logic [1:0]  s1_occ;
  logic        s0_iv, s0_ir, s0_ov, s0_or;
  logic [31:0] s0_d, s0_od;
  logic [1:0]  s0_occ;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(fl),
    .in_valid(s1_iv), .in_ready(s1_ir), .in_data(s1_d),
    .out_valid(s1_ov), .out_ready(s1_or), .out_data(s1_od),
    .occupancy(s1_occ)
  );

  pipe_stage_reg #(.DATA_W(32), .SKID(0)) u_noskid (
    .clk(clk), .reset(reset), .flush(fl),
    .in_valid(s0_iv), .in_ready(s0_ir), .in_data(s0_d),
    .out_valid(s0_ov), .out_ready(s0_or), .out_data(s0_od),
    .occupancy(s0_occ)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] strm [3];
  logic [31:0] q1 [$];
  logic [31:0] q0 [$];
  logic [31:0] nxt1, nxt0;
  int sent1, sent0, rcvd1, rcvd0;

  initial begin
    strm[0] = 32'h11; strm[1] = 32'h22; strm[2] = 32'h33;
    reset = 1'b1; fl = 1'b0;
    s1_iv = 1'b0; s1_d = '0; s1_or = 1'b0;
    s0_iv = 1'b0; s0_d = '0; s0_or = 1'b0;

    // reset held two cycles
    tick; tick;
    check("rst_s1_ov", s1_ov, 0);
    check("rst_s1_od", s1_od, 0);
    check("rst_s1_occ", s1_occ, 0);
    check("rst_s1_ir", s1_ir, 0);
    check("rst_s0_ov", s0_ov, 0);
    check("rst_s0_ir", s0_ir, 0);

    // stream 11,22,33 with out_ready high
    reset = 1'b0;
    s1_iv = 1'b1; s1_or = 1'b1; s0_iv = 1'b1; s0_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s1_d = strm[i]; s0_d = strm[i];
      #1;
      check("strm_s1_ir", s1_ir, 1);
      check("strm_s0_ir", s0_ir, 1);
      tick;
      check("strm_s1_od", s1_od, strm[i]);
      check("strm_s0_od", s0_od, strm[i]);
      check("strm_s1_occ", s1_occ, 1);
      check("strm_s0_occ", s0_occ, 1);
    end
    s1_iv = 1'b0; s0_iv = 1'b0;
    tick;
    check("strm_s1_drain", s1_ov, 0);
    check("strm_s0_drain", s0_ov, 0);
    check("strm_s1_occ0", s1_occ, 0);

    // skid stall: A1 accepted, then out_ready low three cycles
    s1_iv = 1'b1; s1_d = 32'hA1; s1_or = 1'b1;
    tick;
    check("skid_a1", s1_od, 32'hA1);
    s1_or = 1'b0; s1_d = 32'hA2;
    #1;
    check("skid_ir_one", s1_ir, 1);
    tick;
    check("skid_occ2", s1_occ, 2);
    check("skid_hold1", s1_od, 32'hA1);
    check("skid_ir_two", s1_ir, 0);
    s1_d = 32'hA3;
    tick;
    check("skid_occ2b", s1_occ, 2);
    check("skid_hold2", s1_od, 32'hA1);
    check("skid_ir_two_b", s1_ir, 0);
    tick;
    check("skid_hold3", s1_od, 32'hA1);
    check("skid_ov", s1_ov, 1);
    s1_or = 1'b1;
    #1;
    check("skid_ir_noc", s1_ir, 0);
    tick;
    check("skid_a2", s1_od, 32'hA2);
    check("skid_occ1", s1_occ, 1);
    tick;
    check("skid_a3", s1_od, 32'hA3);
    s1_iv = 1'b0;
    tick;
    check("skid_empty", s1_ov, 0);

    // no-skid stall: in_ready drops in the same cycle
    s0_iv = 1'b1; s0_d = 32'hC1; s0_or = 1'b1;
    tick;
    check("ns_c1", s0_od, 32'hC1);
    s0_or = 1'b0; s0_d = 32'hC2;
    #1;
    check("ns_ir_stall", s0_ir, 0);
    tick;
    check("ns_hold1", s0_od, 32'hC1);
    check("ns_ov", s0_ov, 1);
    tick;
    check("ns_hold2", s0_od, 32'hC1);
    s0_or = 1'b1;
    #1;
    check("ns_ir_rel", s0_ir, 1);
    tick;
    check("ns_c2", s0_od, 32'hC2);
    s0_iv = 1'b0;
    tick;
    check("ns_empty", s0_ov, 0);
    check("ns_keep", s0_od, 32'hC2);

    // flush from TWO with a same-cycle offer of 0x55
    s1_iv = 1'b1; s1_d = 32'hB1; s1_or = 1'b0;
    s0_iv = 1'b1; s0_d = 32'hD1; s0_or = 1'b0;
    tick;
    s0_iv = 1'b0; s1_d = 32'hB2;
    tick;
    check("fl_pre_occ", s1_occ, 2);
    check("fl_pre_s0", s0_ov, 1);
    fl = 1'b1; s1_d = 32'h55;
    tick;
    check("fl_s1_ov", s1_ov, 0);
    check("fl_s1_od", s1_od, 0);
    check("fl_s1_occ", s1_occ, 0);
    check("fl_s0_ov", s0_ov, 0);
    check("fl_s0_od", s0_od, 0);
    fl = 1'b0; s1_iv = 1'b0; s1_or = 1'b1;
    tick;
    check("fl_no55", s1_ov, 0);

    // flush from ONE while in_ready is high: offered beat is killed
    s1_iv = 1'b1; s1_d = 32'hE1; s1_or = 1'b0;
    tick;
    fl = 1'b1; s1_d = 32'h66;
    #1;
    check("fl1_ir", s1_ir, 1);
    tick;
    check("fl1_ov", s1_ov, 0);
    check("fl1_occ", s1_occ, 0);
    fl = 1'b0; s1_iv = 1'b0;
    tick;
    check("fl1_no66", s1_ov, 0);

    // reset asserted while holding one entry
    s1_iv = 1'b1; s1_d = 32'h77; s1_or = 1'b0;
    tick;
    check("mr_occ1", s1_occ, 1);
    s1_iv = 1'b0; reset = 1'b1;
    #1;
    check("mr_s1_ir", s1_ir, 0);
    check("mr_s0_ir", s0_ir, 0);
    tick;
    check("mr_ov", s1_ov, 0);
    check("mr_od", s1_od, 0);
    reset = 1'b0;
    #1;
    check("mr_s1_ir_rel", s1_ir, 1);
    check("mr_s0_ir_rel", s0_ir, 1);

    // random in_valid / out_ready, 1000 beats per instance
    nxt1 = 32'h1000_0000; nxt0 = 32'h2000_0000;
    sent1 = 0; sent0 = 0; rcvd1 = 0; rcvd0 = 0;
    for (int cyc = 0; cyc < 20000 && (rcvd1 < 1000 || rcvd0 < 1000); cyc++) begin
      s1_iv = (sent1 < 1000) && ($urandom_range(9) < 7);
      s1_d  = nxt1;
      s1_or = ($urandom_range(9) < 6);
      s0_iv = (sent0 < 1000) && ($urandom_range(9) < 7);
      s0_d  = nxt0;
      s0_or = ($urandom_range(9) < 6);
      #1;
      if (s1_ov && s1_or) begin
        if (q1.size() == 0) check("rnd1_spurious", s1_od, ~s1_d);
        else begin check("rnd1_data", s1_od, q1.pop_front()); rcvd1++; end
      end
      if (s0_ov && s0_or) begin
        if (q0.size() == 0) check("rnd0_spurious", s0_od, ~s0_d);
        else begin check("rnd0_data", s0_od, q0.pop_front()); rcvd0++; end
      end
      if (s1_iv && s1_ir) begin q1.push_back(s1_d); sent1++; nxt1++; end
      if (s0_iv && s0_ir) begin q0.push_back(s0_d); sent0++; nxt0++; end
      tick;
    end
    check("rnd1_count", rcvd1, 1000);
    check("rnd0_count", rcvd0, 1000);
    check("rnd1_left", q1.size(), 0);
    check("rnd0_left", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
